// File: rtl/stream_demux_if.sv
// Stream demux bus: one valid/ready input stream and N valid/ready output lanes.
// The master side is the producer/consumers; the slave side is the demux itself.
interface stream_demux_if #(
    parameter int SEL_BITS   = 2,
    parameter int DATA_WIDTH = 8
);
    localparam int N = 1 << SEL_BITS;

    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_BITS-1:0]     in_sel;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [N-1:0]            out_valid;
    logic [N-1:0]            out_ready;
    logic [N*DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with a 2-entry buffer per lane, so the
// input ready depends only on registered lane occupancy and in_sel.
module stream_demux #(
    parameter int SEL_BITS   = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    stream_demux_if.slave bus
);
    localparam int N = 1 << SEL_BITS;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } lane_state_t;

    logic [N-1:0]            lane_full;
    logic [N-1:0]            lane_valid;
    logic [N-1:0]            lane_push;
    logic [N-1:0]            lane_pop;
    logic [N*DATA_WIDTH-1:0] lane_data;
    logic                    in_ready;
    logic                    push_en;

    // Ready never looks at out_ready: a full lane blocks even while it drains.
    assign in_ready      = !lane_full[bus.in_sel];
    assign push_en       = bus.in_valid && in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = lane_valid;
    assign bus.out_data  = lane_data;

    for (genvar i = 0; i < N; i++) begin : g_lane
        lane_state_t           state_q, state_d;
        logic [DATA_WIDTH-1:0] head_q, head_d;
        logic [DATA_WIDTH-1:0] tail_q, tail_d;

        assign lane_push[i] = push_en && (bus.in_sel == SEL_BITS'(i));
        assign lane_pop[i]  = (state_q != EMPTY) && bus.out_ready[i];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= EMPTY;
                head_q  <= '0;
                tail_q  <= '0;
            end else begin
                state_q <= state_d;
                head_q  <= head_d;
                tail_q  <= tail_d;
            end
        end

        always_comb begin
            state_d = state_q;
            head_d  = head_q;
            tail_d  = tail_q;
            unique case (state_q)
                EMPTY: begin
                    if (lane_push[i]) begin
                        state_d = ONE;
                        head_d  = bus.in_data;
                    end
                end
                ONE: begin
                    // Push and pop together: new word replaces the head, no bubble.
                    if (lane_push[i] && lane_pop[i]) begin
                        head_d = bus.in_data;
                    end else if (lane_push[i]) begin
                        state_d = TWO;
                        tail_d  = bus.in_data;
                    end else if (lane_pop[i]) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (lane_pop[i]) begin
                        state_d = ONE;
                        head_d  = tail_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        assign lane_full[i]  = (state_q == TWO);
        assign lane_valid[i] = (state_q != EMPTY);
        assign lane_data[i*DATA_WIDTH +: DATA_WIDTH] = head_q;
    end
endmodule

// File: tb/tb_stream_demux.sv
// Directed and randomised checks of the 4-lane, 8-bit stream demultiplexer.
module tb_stream_demux;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    stream_demux_if #(.SEL_BITS(2), .DATA_WIDTH(8)) sif ();

    stream_demux #(.SEL_BITS(2), .DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d);
        sif.in_valid = v;
        sif.in_sel   = sel;
        sif.in_data  = d;
        #1;
    endtask

    function automatic logic [7:0] lane(input int i);
        return sif.out_data[i*8 +: 8];
    endfunction

    logic [7:0] mq [4][$];

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst           = 1'b0;
        sif.in_valid  = 1'b0;
        sif.in_sel    = 2'd0;
        sif.in_data   = 8'h00;
        sif.out_ready = 4'b1111;
        #2;
        check_val("rst_valid", 32'(sif.out_valid), 32'h0);
        check_val("rst_data", sif.out_data, 32'h0);
        check_val("rst_ready", 32'(sif.in_ready), 32'h1);
        step();
        rst = 1'b1;
        step();

        // Single path to lane 2
        drive(1'b1, 2'd2, 8'hA5);
        check_val("single_ready", 32'(sif.in_ready), 32'h1);
        step();
        drive(1'b0, 2'd0, 8'h00);
        check_val("single_valid", 32'(sif.out_valid), 32'h4);
        check_val("single_data", 32'(lane(2)), 32'hA5);
        step();
        check_val("single_drained", 32'(sif.out_valid), 32'h0);

        // Fill and stall lane 0
        sif.out_ready = 4'b1110;
        drive(1'b1, 2'd0, 8'h11);
        check_val("fill_r1", 32'(sif.in_ready), 32'h1);
        step();
        drive(1'b1, 2'd0, 8'h22);
        check_val("fill_r2", 32'(sif.in_ready), 32'h1);
        step();
        drive(1'b1, 2'd0, 8'h33);
        check_val("fill_r3", 32'(sif.in_ready), 32'h0);
        check_val("fill_valid", 32'(sif.out_valid), 32'h1);
        check_val("fill_head", 32'(lane(0)), 32'h11);
        step();
        check_val("stall_ready", 32'(sif.in_ready), 32'h0);
        check_val("stall_head", 32'(lane(0)), 32'h11);
        sif.out_ready = 4'b1111;
        #1;
        check_val("pop_same_cycle_ready", 32'(sif.in_ready), 32'h0);
        step();
        check_val("pop1_head", 32'(lane(0)), 32'h22);
        check_val("pop1_ready", 32'(sif.in_ready), 32'h1);
        step();
        drive(1'b0, 2'd0, 8'h00);
        check_val("pop2_head", 32'(lane(0)), 32'h33);
        check_val("pop2_valid", 32'(sif.out_valid), 32'h1);
        step();
        check_val("pop3_empty", 32'(sif.out_valid), 32'h0);

        // Push+pop on lane 3 holding one word
        sif.out_ready = 4'b0111;
        drive(1'b1, 2'd3, 8'h01);
        step();
        check_val("pp_first", 32'(lane(3)), 32'h01);
        sif.out_ready = 4'b1111;
        drive(1'b1, 2'd3, 8'h02);
        check_val("pp_ready", 32'(sif.in_ready), 32'h1);
        step();
        sif.out_ready = 4'b0111;
        drive(1'b0, 2'd0, 8'h00);
        check_val("pp_valid", 32'(sif.out_valid), 32'h8);
        check_val("pp_head", 32'(lane(3)), 32'h02);
        sif.out_ready = 4'b1111;
        step();
        check_val("pp_empty", 32'(sif.out_valid), 32'h0);

        // Lane independence: lane 0 full, lane 1 still accepts
        sif.out_ready = 4'b0000;
        drive(1'b1, 2'd0, 8'hAA);
        step();
        drive(1'b1, 2'd0, 8'hBB);
        step();
        drive(1'b1, 2'd1, 8'h7E);
        check_val("ind_ready", 32'(sif.in_ready), 32'h1);
        step();
        drive(1'b1, 2'd0, 8'hCC);
        check_val("ind_blocked", 32'(sif.in_ready), 32'h0);
        check_val("ind_valid", 32'(sif.out_valid), 32'h3);
        check_val("ind_lane0", 32'(lane(0)), 32'hAA);
        check_val("ind_lane1", 32'(lane(1)), 32'h7E);

        // Reset mid-traffic with lanes 1 and 2 full
        drive(1'b1, 2'd1, 8'h7F);
        step();
        drive(1'b1, 2'd2, 8'hC1);
        step();
        drive(1'b1, 2'd2, 8'hC2);
        step();
        drive(1'b1, 2'd2, 8'hC3);
        check_val("pre_rst_full", 32'(sif.in_ready), 32'h0);
        rst = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(sif.out_valid), 32'h0);
        check_val("async_rst_data", sif.out_data, 32'h0);
        check_val("async_rst_ready", 32'(sif.in_ready), 32'h1);
        step();
        drive(1'b0, 2'd0, 8'h00);
        rst = 1'b1;
        step();
        drive(1'b1, 2'd1, 8'h5A);
        step();
        drive(1'b0, 2'd0, 8'h00);
        check_val("post_rst_valid", 32'(sif.out_valid), 32'h2);
        check_val("post_rst_data", 32'(lane(1)), 32'h5A);
        sif.out_ready = 4'b1111;
        step();
        check_val("post_rst_empty", 32'(sif.out_valid), 32'h0);

        // Random traffic against a per-lane queue model
        for (int c = 0; c < 10000; c++) begin
            logic       v;
            logic [1:0] s;
            logic [7:0] d;
            logic [3:0] rdy;
            logic       r0;
            bit         push_ok;
            v   = 1'($urandom_range(0, 1));
            s   = 2'($urandom_range(0, 3));
            d   = 8'($urandom_range(0, 255));
            rdy = 4'($urandom_range(0, 15));
            sif.out_ready = rdy;
            drive(v, s, d);
            push_ok = (mq[s].size() < 2);
            check_val("rnd_ready", 32'(sif.in_ready), 32'(push_ok));
            r0 = sif.in_ready;
            for (int i = 0; i < 4; i++) begin
                check_val("rnd_valid", 32'(sif.out_valid[i]), 32'(mq[i].size() != 0));
                if (mq[i].size() != 0)
                    check_val("rnd_data", 32'(lane(i)), 32'(mq[i][0]));
            end
            sif.out_ready = ~rdy;
            #1;
            check_val("rnd_ready_vs_out_ready", 32'(sif.in_ready), 32'(r0));
            sif.out_ready = rdy;
            #1;
            @(posedge clk);
            for (int i = 0; i < 4; i++)
                if (rdy[i] && mq[i].size() != 0) void'(mq[i].pop_front());
            if (v && push_ok) mq[s].push_back(d);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
